// File: rtl/bs_row_hit_arbiter.sv
// Row-hit-first arbiter: pops one of NQ request queues per free output slot, favouring the open row.
// Optional BS_STARVE_GUARD_EN forces a row switch once MAX_HITS consecutive hits have been granted.
module bs_row_hit_arbiter #(
    parameter int NQ         = 4,
    parameter int ENTRY_SIZE = 32,
    parameter int ROW_BITS   = 4,
    parameter int MAX_HITS   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NQ-1:0]                             q_empty,
    input  logic [NQ*ROW_BITS-1:0]                    q_row,
    input  logic [NQ*ENTRY_SIZE-1:0]                  q_data,
    output logic [NQ-1:0]                             q_rd_en,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ENTRY_SIZE-1:0]                     out_data,
    output logic [ROW_BITS-1:0]                       out_row,
    output logic [((NQ > 1) ? $clog2(NQ) : 1)-1:0]    out_sel
);

    localparam int SEL_W = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int HIT_W = $clog2(MAX_HITS + 1);

    localparam logic [0:0]       NO_ROW    = 1'b0;
    localparam logic [0:0]       ROW_OPEN  = 1'b1;
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(NQ - 1);
    localparam logic [HIT_W-1:0] HIT_MAX   = HIT_W'(MAX_HITS);

    logic [0:0]            state;
    logic [ROW_BITS-1:0]   open_row;
    logic [HIT_W-1:0]      hit_cnt;
    logic [SEL_W-1:0]      last_grant;

    logic                  slot_free;
    logic                  any_req;
    logic                  grant;
    logic                  hit_grant;
    logic [NQ-1:0]         req;
    logic [NQ-1:0]         hit;
    logic [NQ-1:0]         cand;
    logic [SEL_W-1:0]      pick;
    logic [ROW_BITS-1:0]   pick_row;
    logic [ENTRY_SIZE-1:0] pick_data;

    assign slot_free = !out_valid || out_ready;
    assign req       = ~q_empty;
    assign any_req   = |req;
    // q_rd_en is combinational, so it must be forced low while reset is held, not just after it.
    assign grant     = slot_free && any_req && rst_n;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NQ; i++) begin
            hit[i] = req[i] && (state == ROW_OPEN) &&
                     (q_row[i*ROW_BITS +: ROW_BITS] == open_row);
        end
    end

`ifdef BS_STARVE_GUARD_EN
    // After MAX_HITS back-to-back hits, any waiting miss queue takes priority over the open row.
    assign cand = ((hit_cnt == HIT_MAX) && (|(req & ~hit))) ? (req & ~hit)
                : ((|hit) ? hit : req);
`else
    assign cand = (|hit) ? hit : req;
`endif

    // Round-robin search starting one past the last grant, wrapping modulo NQ.
    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        pick  = last_grant;
        for (int k = 1; k <= NQ; k++) begin
            j = int'(last_grant) + k;
            if (j >= NQ) j = j - NQ;
            if (!found && cand[SEL_W'(j)]) begin
                pick  = SEL_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_row  = '0;
        pick_data = '0;
        hit_grant = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            if (pick == SEL_W'(i)) begin
                pick_row  = q_row[i*ROW_BITS +: ROW_BITS];
                pick_data = q_data[i*ENTRY_SIZE +: ENTRY_SIZE];
                hit_grant = hit[i];
            end
        end
    end

    always_comb begin
        q_rd_en = '0;
        if (grant) q_rd_en[pick] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NO_ROW;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_sel    <= '0;
            open_row   <= '0;
            hit_cnt    <= '0;
            last_grant <= LAST_INIT;
        end else if (slot_free) begin
            if (any_req) begin
                out_valid  <= 1'b1;
                out_data   <= pick_data;
                out_row    <= pick_row;
                out_sel    <= pick;
                open_row   <= pick_row;
                last_grant <= pick;
                state      <= ROW_OPEN;
                if (!hit_grant) begin
                    hit_cnt <= HIT_W'(1);
                end else if (hit_cnt != HIT_MAX) begin
                    hit_cnt <= hit_cnt + HIT_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
                state     <= NO_ROW;
            end
        end
    end

endmodule

// File: tb/tb_bs_row_hit_arbiter.sv
// Self-checking bench for bs_row_hit_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_bs_row_hit_arbiter;

    localparam int NQ         = 4;
    localparam int ENTRY_SIZE = 32;
    localparam int ROW_BITS   = 4;
    localparam int MAX_HITS   = 4;
    localparam int SEL_W      = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NQ-1:0]            q_empty;
    logic [NQ*ROW_BITS-1:0]   q_row;
    logic [NQ*ENTRY_SIZE-1:0] q_data;
    logic [NQ-1:0]            q_rd_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [ENTRY_SIZE-1:0]    out_data;
    logic [ROW_BITS-1:0]      out_row;
    logic [SEL_W-1:0]         out_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what the output slot holds and which row is open, as plain variables.
    bit                    m_valid;
    bit                    m_open;
    logic [ENTRY_SIZE-1:0] m_data;
    logic [ROW_BITS-1:0]   m_row;
    logic [ROW_BITS-1:0]   m_orow;
    int                    m_sel;
    int                    m_last;
    int                    m_hits;

    bs_row_hit_arbiter #(
        .NQ(NQ), .ENTRY_SIZE(ENTRY_SIZE), .ROW_BITS(ROW_BITS), .MAX_HITS(MAX_HITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_row(q_row), .q_data(q_data),
        .q_rd_en(q_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic logic [NQ*ROW_BITS-1:0] rows(input int a, input int b, input int c, input int d);
        return {ROW_BITS'(d), ROW_BITS'(c), ROW_BITS'(b), ROW_BITS'(a)};
    endfunction

    function automatic logic [ROW_BITS-1:0] row_of(input int i);
        return q_row[i*ROW_BITS +: ROW_BITS];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_open = 0; m_data = '0; m_row = '0; m_orow = '0;
        m_sel = 0; m_last = NQ - 1; m_hits = 0;
    endtask

    // Expected grant for the current inputs: -1 when nothing should pop.
    task automatic model_pick(output int pick, output bit hit_grant);
        bit [NQ-1:0] ne, hits, use_m;
        pick = -1;
        hit_grant = 0;
        ne = ~q_empty;
        hits = '0;
        for (int i = 0; i < NQ; i++)
            if (m_open && ne[i] && row_of(i) == m_orow) hits[i] = 1'b1;
        use_m = (hits != 0) ? hits : ne;
`ifdef BS_STARVE_GUARD_EN
        if (m_open && m_hits == MAX_HITS && (ne & ~hits) != 0) use_m = ne & ~hits;
`endif
        if (!m_valid || out_ready) begin
            for (int k = 1; k <= NQ; k++) begin
                int idx;
                idx = (m_last + k) % NQ;
                if (pick < 0 && use_m[idx]) begin
                    pick = idx;
                    hit_grant = hits[idx];
                end
            end
        end
    endtask

    // One clock: drive inputs after the falling edge, check pops, then check registered outputs after the rising edge.
    task automatic step(input logic [NQ-1:0] e, input logic [NQ*ROW_BITS-1:0] r, input bit rdy);
        int pick;
        bit hg;
        bit free;
        logic [NQ-1:0] exp_rd;
        q_empty = e;
        q_row = r;
        out_ready = rdy;
        for (int i = 0; i < NQ; i++) q_data[i*ENTRY_SIZE +: ENTRY_SIZE] = $urandom;
        #1;
        free = !m_valid || rdy;
        model_pick(pick, hg);
        exp_rd = (pick >= 0) ? (NQ'(1) << pick) : '0;
        check("q_rd_en", q_rd_en, exp_rd);
        @(posedge clk);
        if (free) begin
            if (pick >= 0) begin
                m_hits  = (m_open && hg) ? ((m_hits < MAX_HITS) ? m_hits + 1 : MAX_HITS) : 1;
                m_valid = 1;
                m_data  = q_data[pick*ENTRY_SIZE +: ENTRY_SIZE];
                m_row   = row_of(pick);
                m_sel   = pick;
                m_last  = pick;
                m_open  = 1;
                m_orow  = m_row;
            end else begin
                m_valid = 0;
                m_open  = 0;
            end
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_row", out_row, m_row);
        check("out_sel", out_sel, m_sel);
        check("hit_cnt", dut.hit_cnt, m_hits);
        @(negedge clk);
    endtask

    // Pull reset between edges with every queue non-empty; outputs must clear with no clock and no pop.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        q_empty = '0;
        out_ready = 1'b1;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_q_rd_en", q_rd_en, 0);
        @(posedge clk);
        #1;
        check("rst_hold_q_rd_en", q_rd_en, 0);
        check("rst_hold_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NQ*ROW_BITS-1:0] rr;
        rst_n = 1'b0;
        q_empty = '0;
        q_row = '0;
        q_data = '0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_out_data", out_data, 0);
        check("init_out_sel", out_sel, 0);
        check("init_q_rd_en", q_rd_en, 0);
        check("init_hit_cnt", dut.hit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Queues 0 and 2 non-empty: pop 0, then 2, then drain.
        step(4'b1010, rows(1, 0, 2, 0), 1'b1);
        step(4'b1011, rows(1, 0, 2, 0), 1'b1);
        step(4'b1111, rows(1, 0, 2, 0), 1'b1);

        // Row hit beats round-robin: q0 row 3, then q1 row 3 vs q2 row 5.
        step(4'b1110, rows(3, 0, 0, 0), 1'b1);
        step(4'b1001, rows(0, 3, 5, 0), 1'b1);

        // Four row-3 grants, then back-pressure for three cycles.
        for (int i = 0; i < 4; i++) step(4'b0000, rows(3, 3, 3, 3), 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, rows(3, 3, 3, 3), 1'b0);
        step(4'b0000, rows(3, 3, 3, 3), 1'b1);

        // Sustained row-3 hits while queue 2 waits on row 5.
        for (int i = 0; i < 7; i++) step(4'b1000, rows(3, 3, 5, 0), 1'b1);

        // Reset mid-grant, then first grant goes to queue 0.
        async_reset();
        step(4'b0000, rows(7, 7, 7, 7), 1'b1);

        // Drain, then a stale open row must not count as a hit.
        step(4'b1111, rows(7, 7, 7, 7), 1'b1);
        step(4'b0000, rows(2, 7, 7, 7), 1'b1);
        step(4'b1111, rows(2, 7, 7, 7), 1'b0);

        // Randomized traffic with a narrow row range so hits are frequent.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NQ; i++) rr[i*ROW_BITS +: ROW_BITS] = ROW_BITS'($urandom_range(0, 2));
            if (n % 97 == 50) async_reset();
            step(NQ'($urandom), rr, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
